// File: rtl/uart_tx.sv
// UART serial transmitter: start(0), BITS data bits LSB-first, optional even parity, stop(1).
// Define UART_TX_PARITY_EN to insert the parity bit between the data and stop bits.
module uart_tx #(
  parameter int START_TICKS = 16,
  parameter int DATA_TICKS  = 16,
  parameter int STOP_TICKS  = 16,
  parameter int BITS        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ticks,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       Tx,
  output logic       tx_busy,
  output logic       tx_done
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  localparam logic [4:0] START_LAST = 5'(START_TICKS - 1);
  localparam logic [4:0] DATA_LAST  = 5'(DATA_TICKS - 1);
  localparam logic [4:0] STOP_LAST  = 5'(STOP_TICKS - 1);
  localparam logic [3:0] BIT_LAST   = 4'(BITS - 1);

  state_t     state;
  logic [4:0] tick_cnt;
  logic [3:0] bit_cnt;
  logic [7:0] shift;
`ifdef UART_TX_PARITY_EN
  logic       par;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      Tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          Tx <= 1'b1;
          if (tx_start) begin
            shift    <= tx_data;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            state    <= START;
            Tx       <= 1'b0;
            tx_busy  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
          end
        end

        START: begin
          if (ticks) begin
            if (tick_cnt == START_LAST) begin
              tick_cnt <= '0;
              state    <= DATA;
              Tx       <= shift[0];
            end else begin
              tick_cnt <= tick_cnt + 5'd1;
            end
          end
        end

        DATA: begin
          if (ticks) begin
            if (tick_cnt == DATA_LAST) begin
              tick_cnt <= '0;
              shift    <= {1'b0, shift[7:1]};
              bit_cnt  <= bit_cnt + 4'd1;
`ifdef UART_TX_PARITY_EN
              par      <= par ^ shift[0];
`endif
              if (bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                state <= PARITY;
                Tx    <= par ^ shift[0];
`else
                state <= STOP;
                Tx    <= 1'b1;
`endif
              end else begin
                // Next bit is shift[1] because the shift lands on this same edge.
                Tx <= shift[1];
              end
            end else begin
              tick_cnt <= tick_cnt + 5'd1;
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (ticks) begin
            if (tick_cnt == DATA_LAST) begin
              tick_cnt <= '0;
              state    <= STOP;
              Tx       <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt + 5'd1;
            end
          end
        end
`endif

        STOP: begin
          Tx <= 1'b1;
          if (ticks) begin
            if (tick_cnt == STOP_LAST) begin
              tick_cnt <= '0;
              state    <= IDLE;
              tx_busy  <= 1'b0;
              tx_done  <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt + 5'd1;
            end
          end
        end

        default: begin
          state   <= IDLE;
          Tx      <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
